// File: rtl/decryption_regfile_initiator_if.sv
// Register-access bus between the decryption initiator (master) and the key register file (slave).
// Strobes, address and write data come from the master; rdata/done/error return from the slave.
interface decryption_regfile_initiator_if #(
    parameter int addr_witdth = 8,
    parameter int reg_width   = 16
);
    logic [addr_witdth-1:0] addr;
    logic                   read;
    logic                   write;
    logic [reg_width-1:0]   wdata;
    logic [reg_width-1:0]   rdata;
    logic                   done;
    logic                   error;

    modport master (output addr, read, write, wdata, input rdata, done, error);
    modport slave  (input addr, read, write, wdata, output rdata, done, error);
endinterface

// File: rtl/decryption_regfile_initiator.sv
// Key register-file bus initiator: single host commands plus a 4-key bulk loader; CMD_TIMEOUT_EN adds a done timeout.
// Latency: strobe one cycle after accept, response one cycle after done is sampled (4 cycles with a 1-cycle responder).
// Backpressure: cmd_ready is high only in IDLE without load_start; WAIT holds until done (or timeout when enabled).
module decryption_regfile_initiator #(
    parameter int addr_witdth = 8,
    parameter int reg_width   = 16
`ifdef CMD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [addr_witdth-1:0] cmd_addr,
    input  logic [reg_width-1:0]   cmd_wdata,
    output logic                   rsp_valid,
    output logic [reg_width-1:0]   rsp_rdata,
    output logic                   rsp_error,
    input  logic                   load_start,
    input  logic [reg_width-1:0]   load_select,
    input  logic [reg_width-1:0]   load_caesar,
    input  logic [reg_width-1:0]   load_scytale,
    input  logic [reg_width-1:0]   load_zigzag,
    output logic                   load_done,
    output logic                   load_error,
    decryption_regfile_initiator_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t                 state, state_nxt;
    logic                   is_load, is_load_nxt;
    logic [1:0]             idx, idx_nxt;
    logic [reg_width-1:0]   keys [4];
    logic [reg_width-1:0]   keys_nxt [4];
    logic                   cur_write, cur_write_nxt;
    logic [addr_witdth-1:0] cur_addr, cur_addr_nxt;
    logic [reg_width-1:0]   cur_wdata, cur_wdata_nxt;
    logic [reg_width-1:0]   rd_cap, rd_cap_nxt;
    logic                   err_cap, err_cap_nxt;
    logic [addr_witdth-1:0] addr_q, addr_nxt;
    logic [reg_width-1:0]   wdata_q, wdata_nxt;
    logic                   read_q, read_nxt;
    logic                   write_q, write_nxt;
    logic                   rsp_valid_nxt, rsp_error_nxt;
    logic [reg_width-1:0]   rsp_rdata_nxt;
    logic                   load_done_nxt, load_error_nxt;
`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]          tmo_cnt, tmo_cnt_nxt;
`endif

    // Fixed key-register map: select, caesar, scytale, zigzag.
    function automatic logic [addr_witdth-1:0] key_addr(input logic [1:0] i);
        case (i)
            2'd0:    key_addr = addr_witdth'(8'h00);
            2'd1:    key_addr = addr_witdth'(8'h10);
            2'd2:    key_addr = addr_witdth'(8'h12);
            default: key_addr = addr_witdth'(8'h14);
        endcase
    endfunction

    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign bus.read  = read_q;
    assign bus.write = write_q;
    assign cmd_ready = (state == IDLE) && !load_start;

    always_comb begin
        state_nxt      = state;
        is_load_nxt    = is_load;
        idx_nxt        = idx;
        keys_nxt       = keys;
        cur_write_nxt  = cur_write;
        cur_addr_nxt   = cur_addr;
        cur_wdata_nxt  = cur_wdata;
        rd_cap_nxt     = rd_cap;
        err_cap_nxt    = err_cap;
        addr_nxt       = addr_q;
        wdata_nxt      = wdata_q;
        read_nxt       = read_q;
        write_nxt      = write_q;
        rsp_valid_nxt  = 1'b0;
        rsp_rdata_nxt  = '0;
        rsp_error_nxt  = 1'b0;
        load_done_nxt  = 1'b0;
        load_error_nxt = load_error;
`ifdef CMD_TIMEOUT_EN
        tmo_cnt_nxt    = tmo_cnt;
`endif
        case (state)
            IDLE: begin
                if (load_start) begin
                    keys_nxt[0]    = load_select;
                    keys_nxt[1]    = load_caesar;
                    keys_nxt[2]    = load_scytale;
                    keys_nxt[3]    = load_zigzag;
                    idx_nxt        = 2'd0;
                    is_load_nxt    = 1'b1;
                    load_error_nxt = 1'b0;
                    state_nxt      = ISSUE;
                end else if (cmd_valid) begin
                    cur_write_nxt = cmd_write;
                    cur_addr_nxt  = cmd_addr;
                    cur_wdata_nxt = cmd_wdata;
                    is_load_nxt   = 1'b0;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                addr_nxt  = is_load ? key_addr(idx) : cur_addr;
                wdata_nxt = is_load ? keys[idx] : cur_wdata;
                write_nxt = is_load || cur_write;
                read_nxt  = !(is_load || cur_write);
                state_nxt = WAIT;
`ifdef CMD_TIMEOUT_EN
                tmo_cnt_nxt = '0;
`endif
            end
            WAIT: begin
                if (bus.done) begin
                    read_nxt    = 1'b0;
                    write_nxt   = 1'b0;
                    rd_cap_nxt  = (read_q && !bus.error) ? bus.rdata : '0;
                    err_cap_nxt = bus.error;
                    state_nxt   = GAP;
                end
`ifdef CMD_TIMEOUT_EN
                else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    read_nxt    = 1'b0;
                    write_nxt   = 1'b0;
                    rd_cap_nxt  = '0;
                    err_cap_nxt = 1'b1;
                    state_nxt   = GAP;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                end
`endif
            end
            default: begin
                // GAP: bus stays idle this cycle so the responder rearms before the next strobe.
                if (is_load) begin
                    load_error_nxt = load_error | err_cap;
                    if (idx == 2'd3) begin
                        load_done_nxt = 1'b1;
                        state_nxt     = IDLE;
                    end else begin
                        idx_nxt   = idx + 2'd1;
                        state_nxt = ISSUE;
                    end
                end else begin
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = rd_cap;
                    rsp_error_nxt = err_cap;
                    state_nxt     = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            is_load    <= 1'b0;
            idx        <= 2'd0;
            for (int i = 0; i < 4; i++) keys[i] <= '0;
            cur_write  <= 1'b0;
            cur_addr   <= '0;
            cur_wdata  <= '0;
            rd_cap     <= '0;
            err_cap    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_error  <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            state      <= state_nxt;
            is_load    <= is_load_nxt;
            idx        <= idx_nxt;
            keys       <= keys_nxt;
            cur_write  <= cur_write_nxt;
            cur_addr   <= cur_addr_nxt;
            cur_wdata  <= cur_wdata_nxt;
            rd_cap     <= rd_cap_nxt;
            err_cap    <= err_cap_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
            read_q     <= read_nxt;
            write_q    <= write_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_rdata  <= rsp_rdata_nxt;
            rsp_error  <= rsp_error_nxt;
            load_done  <= load_done_nxt;
            load_error <= load_error_nxt;
`ifdef CMD_TIMEOUT_EN
            tmo_cnt    <= tmo_cnt_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_decryption_regfile_initiator.sv
// Bench for decryption_regfile_initiator: behavioural key-regfile responder, address-map model and bus monitor.
module tb_decryption_regfile_initiator;
    typedef struct packed {
        logic        write;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid, rsp_error;
    logic [15:0] rsp_rdata;
    logic        load_start, load_done, load_error;
    logic [15:0] load_select, load_caesar, load_scytale, load_zigzag;

    decryption_regfile_initiator_if bus ();

    decryption_regfile_initiator dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .load_start(load_start), .load_select(load_select), .load_caesar(load_caesar),
        .load_scytale(load_scytale), .load_zigzag(load_zigzag),
        .load_done(load_done), .load_error(load_error),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // ---------------- responder: key register file with variable done latency ----------------
    logic [15:0] rf [4];
    logic        r_done = 1'b0, r_err = 1'b0, r_busy = 1'b0;
    logic [15:0] r_rdata = '0;
    logic        spur, hang;
    int          r_wait = 0, r_lat = 0, lat_max;
    logic [7:0]  inj_addr;

    function automatic int slot(input logic [7:0] a);
        case (a)
            8'h00:   return 0;
            8'h10:   return 1;
            8'h12:   return 2;
            8'h14:   return 3;
            default: return -1;
        endcase
    endfunction

    assign bus.done  = r_done | spur;
    assign bus.error = r_err;
    assign bus.rdata = r_rdata;

    always @(posedge clk) begin
        int s;
        r_done  <= 1'b0;
        r_err   <= 1'b0;
        r_rdata <= '0;
        if (rst) begin
            r_busy <= 1'b0;
            r_wait <= 0;
            rf[0] <= 16'h0000; rf[1] <= 16'h0000; rf[2] <= 16'hFFFF; rf[3] <= 16'h0002;
        end else if (!(bus.read || bus.write)) begin
            r_busy <= 1'b0;
            r_wait <= 0;
        end else if (!r_busy && !hang) begin
            if (r_wait >= r_lat) begin
                s = slot(bus.addr);
                r_done <= 1'b1;
                r_busy <= 1'b1;
                r_wait <= 0;
                r_lat  <= int'($urandom_range(0, lat_max));
                if (s < 0 || bus.addr == inj_addr) begin
                    r_err   <= 1'b1;
                    r_rdata <= 16'hDEAD;
                end else if (bus.write) rf[s] <= bus.wdata;
                else r_rdata <= rf[s];
            end else r_wait <= r_wait + 1;
        end
    end

    // ---------------- bus monitor ----------------
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    txn_t bus_log[$];
    int   gap_log[$];
    int   stb_rise_cyc = 0, done_cyc = 0, stb_len = 0, low_len = 0;
    int   rw_both = 0, gap_viol = 0, stab_viol = 0;
    logic p_stb = 1'b0, p_done = 1'b0;
    txn_t p_txn = '0;

    always @(negedge clk) begin
        logic stb;
        txn_t cur;
        stb = bus.read | bus.write;
        cur = {bus.write, bus.addr, bus.wdata};
        if (bus.read && bus.write) rw_both++;
        if (stb && p_stb && p_done) gap_viol++;
        if (stb && p_stb && !p_done && cur != p_txn) stab_viol++;
        if (stb && !p_stb) begin
            bus_log.push_back(cur);
            gap_log.push_back(low_len);
            stb_rise_cyc = cyc;
            stb_len = 0;
        end
        if (stb) begin
            stb_len++;
            low_len = 0;
        end else low_len++;
        if (stb && bus.done) done_cyc = cyc;
        p_stb  = stb;
        p_done = bus.done;
        p_txn  = cur;
    end

    // ---------------- reference model: register map contents ----------------
    logic [15:0] mreg [logic [7:0]];

    task automatic init_model();
        mreg.delete();
        mreg[8'h00] = 16'h0000;
        mreg[8'h10] = 16'h0000;
        mreg[8'h12] = 16'hFFFF;
        mreg[8'h14] = 16'h0002;
    endtask

    task automatic do_cmd(input logic w, input logic [7:0] a, input logic [15:0] d);
        logic        exp_err, got;
        logic [15:0] exp_rd;
        int          acc, rcyc;
        txn_t        t;
        exp_err = !mreg.exists(a) || a == inj_addr || hang;
        exp_rd  = (!w && !exp_err) ? mreg[a] : 16'h0000;
        if (w && !exp_err) mreg[a] = d;
        bus_log.delete();
        gap_log.delete();
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        got = 1'b0; acc = 0; rcyc = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (cmd_ready) begin got = 1'b1; acc = cyc; end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check("cmd_accept", got, 1);
        got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1'b1; rcyc = cyc; end
        end
        check("rsp_seen", got, 1);
        if (got) begin
            check("rsp_rdata", rsp_rdata, exp_rd);
            check("rsp_error", rsp_error, exp_err);
            check("strobe_latency", stb_rise_cyc - acc, 2);
            if (!hang) check("rsp_latency", rcyc - done_cyc, 2);
        end
        check("bus_txn_count", bus_log.size(), 1);
        if (bus_log.size() > 0) begin
            t = bus_log.pop_front();
            check("bus_dir", t.write, w);
            check("bus_addr", t.addr, a);
            if (w) check("bus_wdata", t.wdata, d);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_load(input logic [15:0] s, input logic [15:0] c, input logic [15:0] sc, input logic [15:0] z);
        logic [15:0] v [4];
        logic [7:0]  la [4];
        logic        exp_err, got;
        int          rdy_viol, rsp_cnt;
        txn_t        t;
        v  = '{s, c, sc, z};
        la = '{8'h00, 8'h10, 8'h12, 8'h14};
        exp_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (la[i] == inj_addr) exp_err = 1'b1;
            else mreg[la[i]] = v[i];
        end
        bus_log.delete();
        gap_log.delete();
        load_start = 1'b1;
        load_select = s; load_caesar = c; load_scytale = sc; load_zigzag = z;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 16'hBEEF;
        @(negedge clk);
        check("load_blocks_cmd", cmd_ready, 0);
        @(posedge clk); #1;
        load_start = 1'b0; cmd_valid = 1'b0;
        load_select = ~s; load_caesar = ~c; load_scytale = ~sc; load_zigzag = ~z;
        got = 1'b0; rdy_viol = 0; rsp_cnt = 0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid) rsp_cnt++;
            if (load_done) begin
                got = 1'b1;
                check("load_error", load_error, exp_err);
            end else if (cmd_ready) rdy_viol++;
        end
        check("load_done_seen", got, 1);
        check("load_ready_low", rdy_viol, 0);
        check("load_no_rsp", rsp_cnt, 0);
        @(negedge clk);
        check("load_done_pulse", load_done, 0);
        check("load_txn_count", bus_log.size(), 4);
        for (int i = 0; i < 4 && bus_log.size() > 0; i++) begin
            t = bus_log.pop_front();
            check("load_dir", t.write, 1);
            check("load_addr", t.addr, la[i]);
            check("load_wdata", t.wdata, v[i]);
            if (i > 0) check("load_gap", gap_log[i], 2);
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [7:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'h10;
            2:       return 8'h12;
            3:       return 8'h14;
            4:       return 8'h20;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic got;
        int   n_rsp, n_stb;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        load_start = 1'b0; load_select = '0; load_caesar = '0; load_scytale = '0; load_zigzag = '0;
        spur = 1'b0; hang = 1'b0; lat_max = 0; inj_addr = 8'hFF;
        init_model();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_outputs", {rsp_valid, rsp_error, rsp_rdata, load_done, load_error, bus.read, bus.write}, 0);
        check("rst_bus", {bus.addr, bus.wdata}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", cmd_ready, 1);
        @(posedge clk); #1;

        // directed traffic with a one-cycle responder
        do_cmd(1'b0, 8'h12, 16'h0000);
        do_cmd(1'b0, 8'h14, 16'h0000);
        do_cmd(1'b1, 8'h10, 16'h0003);
        check("rf_caesar", rf[1], 16'h0003);
        do_cmd(1'b0, 8'h20, 16'h0000);
        do_cmd(1'b1, 8'h14, 16'h0005);
        do_cmd(1'b0, 8'h14, 16'h0000);
        do_load(16'h0001, 16'h0007, 16'h0004, 16'h0003);
        do_cmd(1'b0, 8'h10, 16'h0000);
        inj_addr = 8'h12;
        do_load(16'h0011, 16'h0022, 16'h0033, 16'h0044);
        inj_addr = 8'hFF;
        do_cmd(1'b0, 8'h12, 16'h0000);
        do_cmd(1'b0, 8'h14, 16'h0000);

        // done pulse while idle must be ignored
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        n_rsp = 0; n_stb = 0;
        repeat (5) begin
            @(negedge clk);
            n_rsp += int'(rsp_valid);
            n_stb += int'(bus.read | bus.write);
        end
        check("spur_no_rsp", n_rsp, 0);
        check("spur_no_strobe", n_stb, 0);
        check("spur_ready", cmd_ready, 1);
        @(posedge clk); #1;

        // reset while waiting for done
        hang = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h14;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            got = bus.read;
        end
        check("rstw_strobe_up", got, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstw_strobe_low", {bus.read, bus.write}, 0);
        check("rstw_ready", cmd_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0; hang = 1'b0;
        init_model();
        n_rsp = 0;
        repeat (6) begin
            @(negedge clk);
            n_rsp += int'(rsp_valid) + int'(load_done);
        end
        check("rstw_no_rsp", n_rsp, 0);
        @(posedge clk); #1;

`ifdef CMD_TIMEOUT_EN
        hang = 1'b1;
        do_cmd(1'b0, 8'h10, 16'h0000);
        check("tmo_strobe_len", stb_len, 16);
        hang = 1'b0;
        do_cmd(1'b1, 8'h10, 16'h1234);
        do_cmd(1'b0, 8'h10, 16'h0000);
`endif

        // randomized traffic with variable responder latency
        lat_max = 3;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0)
                do_load(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            else
                do_cmd(1'($urandom_range(0, 1)), pick_addr(), 16'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        check("never_read_and_write", rw_both, 0);
        check("strobe_gap", gap_viol, 0);
        check("strobe_stable", stab_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
